pwr_gate_seq: RTL and testbench

Power-gating sequencer for one switchable logic domain built from SAED90nm cells. It enables header-switch groups in staggered steps to limit inrush current, waits for power-good, then runs the retention-restore and isolation-release sequence. Power-down runs the reverse order. It sits between the power-management requester and the domain's switch, isolation and retention controls.

---
 rtl/pwr_gate_seq.sv | 161 ++++++++++++++++
 tb/tb_pwr_gate_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pwr_gate_seq.sv
// Power-gating sequencer: staggered header-switch ramp, power-good wait,
// restore/un-isolate on the way up and save/isolate on the way down.
module pwr_gate_seq #(
    parameter int NGRP     = 4,
    parameter int STEP_CYC = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            pwr_req,
    input  logic            pgood,
    output logic [NGRP-1:0] sw_en,
    output logic            iso_en,
    output logic            save,
    output logic            restore,
    output logic            pwr_ack,
    output logic            busy,
    output logic            err
);

    localparam int MAXC = (STEP_CYC > TIMEOUT) ? STEP_CYC : TIMEOUT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_RAMP    = 4'd1,
        ST_WAIT_PG = 4'd2,
        ST_RESTORE = 4'd3,
        ST_UNISO   = 4'd4,
        ST_ON      = 4'd5,
        ST_SAVE    = 4'd6,
        ST_ISO     = 4'd7,
        ST_FAULT   = 4'd8
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;

    // Sequencer state, shared step/timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r <= ST_OFF;
            cnt_r   <= '0;
            sw_en   <= '0;
            iso_en  <= 1'b1;
            save    <= 1'b0;
            restore <= 1'b0;
            pwr_ack <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    if (pwr_req) begin
                        state_r <= ST_RAMP;
                        sw_en   <= NGRP'(1'b1);
                        busy    <= 1'b1;
                    end
                    cnt_r <= '0;
                end
                ST_RAMP: begin
                    if (!pwr_req) begin
                        // Abort: drop every group at once, nothing to save yet
                        state_r <= ST_OFF;
                        sw_en   <= '0;
                        busy    <= 1'b0;
                        cnt_r   <= '0;
                    end else if (cnt_r == STEP_LAST) begin
                        cnt_r <= '0;
                        if (sw_en[NGRP-1]) begin
                            state_r <= ST_WAIT_PG;
                        end else begin
                            sw_en <= (sw_en << 1) | NGRP'(1'b1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_WAIT_PG: begin
                    cnt_r <= '0;
                    if (!pwr_req) begin
                        state_r <= ST_OFF;
                        sw_en   <= '0;
                        busy    <= 1'b0;
                    end else if (pgood) begin
                        state_r <= ST_RESTORE;
                        restore <= 1'b1;
                    end else if (cnt_r == TO_LAST) begin
                        state_r <= ST_FAULT;
                        sw_en   <= '0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_RESTORE: begin
                    state_r <= ST_UNISO;
                    restore <= 1'b0;
                    iso_en  <= 1'b0;
                    cnt_r   <= '0;
                end
                ST_UNISO: begin
                    state_r <= ST_ON;
                    pwr_ack <= 1'b1;
                    busy    <= 1'b0;
                    cnt_r   <= '0;
                end
                ST_ON: begin
                    // Brown-out takes priority over an orderly power-down
                    if (!pgood) begin
                        state_r <= ST_FAULT;
                        sw_en   <= '0;
                        iso_en  <= 1'b1;
                        pwr_ack <= 1'b0;
                        err     <= 1'b1;
                    end else if (!pwr_req) begin
                        state_r <= ST_SAVE;
                        pwr_ack <= 1'b0;
                        save    <= 1'b1;
                        busy    <= 1'b1;
                    end
                    cnt_r <= '0;
                end
                ST_SAVE: begin
                    state_r <= ST_ISO;
                    save    <= 1'b0;
                    iso_en  <= 1'b1;
                    cnt_r   <= '0;
                end
                ST_ISO: begin
                    state_r <= ST_OFF;
                    sw_en   <= '0;
                    busy    <= 1'b0;
                    cnt_r   <= '0;
                end
                ST_FAULT: begin
                    if (!pwr_req) begin
                        state_r <= ST_OFF;
                        err     <= 1'b0;
                    end
                    cnt_r <= '0;
                end
                default: begin
                    state_r <= ST_OFF;
                    cnt_r   <= '0;
                    sw_en   <= '0;
                    iso_en  <= 1'b1;
                    save    <= 1'b0;
                    restore <= 1'b0;
                    pwr_ack <= 1'b0;
                    busy    <= 1'b0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwr_gate_seq.sv
// Directed bench for pwr_gate_seq: reset, ramp timing, power-down, abort,
// power-good timeout and priority, brown-out and mid-sequence reset.
module tb_pwr_gate_seq;

    localparam int NGRP     = 4;
    localparam int STEP_CYC = 8;
    localparam int TIMEOUT  = 255;

    logic            clk = 1'b0;
    logic            rstb;
    logic            pwr_req;
    logic            pgood;
    logic [NGRP-1:0] sw_en;
    logic            iso_en;
    logic            save;
    logic            restore;
    logic            pwr_ack;
    logic            busy;
    logic            err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwr_gate_seq #(.NGRP(NGRP), .STEP_CYC(STEP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .pwr_req (pwr_req),
        .pgood   (pgood),
        .sw_en   (sw_en),
        .iso_en  (iso_en),
        .save    (save),
        .restore (restore),
        .pwr_ack (pwr_ack),
        .busy    (busy),
        .err     (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] e_sw, input logic e_iso,
                              input logic e_save, input logic e_rst, input logic e_ack,
                              input logic e_busy, input logic e_err);
        check_val({tag, ".sw_en"},   32'(sw_en),   32'(e_sw));
        check_val({tag, ".iso_en"},  32'(iso_en),  32'(e_iso));
        check_val({tag, ".save"},    32'(save),    32'(e_save));
        check_val({tag, ".restore"}, 32'(restore), 32'(e_rst));
        check_val({tag, ".pwr_ack"}, 32'(pwr_ack), 32'(e_ack));
        check_val({tag, ".busy"},    32'(busy),    32'(e_busy));
        check_val({tag, ".err"},     32'(err),     32'(e_err));
    endtask

    // Advance one rising edge, then settle 1 time unit before checking/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [3:0] exp_sw;

        // Reset with request already high
        rstb = 1'b0; pwr_req = 1'b1; pgood = 1'b1;
        ticks(2);
        check_outs("reset", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstb = 1'b1;
        tick();                                   // edge k
        check_outs("up0", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full power-up with PGOOD already high
        for (int t = 1; t <= 36; t++) begin
            tick();
            exp_sw = (t < 8) ? 4'h1 : (t < 16) ? 4'h3 : (t < 24) ? 4'h7 : 4'hF;
            check_outs($sformatf("up%0d", t), exp_sw, (t < 34), 1'b0, (t == 33),
                       (t >= 35), (t < 35), 1'b0);
        end

        // Orderly power-down
        pwr_req = 1'b0;
        tick();                                   // edge m
        check_outs("pd0", 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_outs("pd1", 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_outs("pd2", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("pd3", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort mid-ramp, then restart from group 0
        pwr_req = 1'b1;
        tick();
        check_outs("ab0", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(8);
        check_outs("ab8", 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pwr_req = 1'b0;
        tick();
        check_outs("ab_off", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pwr_req = 1'b1;
        tick();
        check_outs("ab_re", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        check_outs("ab_re1", 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pwr_req = 1'b0;
        tick();
        check_outs("ab_off2", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // PGOOD arriving on the timeout edge wins over the fault
        pgood = 1'b0; pwr_req = 1'b1;
        tick();                                   // edge k
        ticks(32);                                // k+32: WAIT_PG entered
        check_outs("pgw32", 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(254);                               // k+286
        check_outs("pgw286", 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pgood = 1'b1;
        tick();                                   // k+287
        check_outs("pgw287", 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        ticks(2);
        check_outs("pgw_on", 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Brown-out in ON
        pgood = 1'b0;
        tick();
        check_outs("bo", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pwr_req = 1'b0;
        tick();
        check_outs("bo_clr", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Power-good timeout
        pwr_req = 1'b1;
        tick();                                   // edge k
        ticks(32 + 254);                          // k+286
        check_outs("to286", 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();                                   // k+287
        check_outs("to287", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(3);
        check_outs("to_hold", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pwr_req = 1'b0;
        tick();
        check_outs("to_clr", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted while waiting for power-good
        pwr_req = 1'b1;
        tick();
        ticks(33);
        check_outs("rw_wait", 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rstb = 1'b0;
        tick();
        check_outs("rw_rst", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rstb = 1'b1; pwr_req = 1'b0;
        tick();
        check_outs("rw_off", 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
